// File: rtl/stage_ex_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stage_ex_pkg
// Brief    : Shared EX-stage definitions: mul/div op codes, FSM states, defaults.
// Revision : 1.0
// ============================================================================
package stage_ex_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_TAG_W = 5;

    localparam logic [1:0] MD_MUL  = 2'b00;
    localparam logic [1:0] MD_MULU = 2'b01;
    localparam logic [1:0] MD_DIV  = 2'b10;
    localparam logic [1:0] MD_DIVU = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } md_state_e;

endpackage
`default_nettype wire

// File: rtl/stage_ex_muldiv_if.sv
`default_nettype none
// ============================================================================
// Module   : stage_ex_muldiv_if
// Brief    : Start/busy/done handshake and operand/result bus of the mul/div unit.
// Revision : 1.0
// ============================================================================
interface stage_ex_muldiv_if
    import stage_ex_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int TAG_W = DEF_TAG_W
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [TAG_W-1:0] rw_in;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [TAG_W-1:0] rw_out;

    modport master (
        output start, op, a, b, rw_in, flush,
        input  busy, done, hi, lo, rw_out
    );

    modport slave (
        input  start, op, a, b, rw_in, flush,
        output busy, done, hi, lo, rw_out
    );
endinterface
`default_nettype wire

// File: rtl/stage_ex_muldiv_step.sv
`default_nettype none
// ============================================================================
// Module   : stage_ex_muldiv_step
// Brief    : One radix-2 iteration: shift-add multiply or restoring divide.
// Revision : 1.0
// ============================================================================
module stage_ex_muldiv_step #(
    parameter int WIDTH = 32
) (
    input  wire logic [2*WIDTH-1:0] i_acc,
    input  wire logic [WIDTH-1:0]   i_opnd,
    input  wire logic               i_is_div,
    output logic      [2*WIDTH-1:0] o_acc
);
    // Multiply: acc = {partial product, remaining multiplier bits}.
    // Divide:   acc = {partial remainder, dividend shifting into quotient}.
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_rem_sh;
    logic [WIDTH:0] w_trial;

    always_comb begin
        w_sum    = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_opnd} : '0);
        w_rem_sh = {i_acc[2*WIDTH-1:WIDTH], i_acc[WIDTH-1]};
        w_trial  = w_rem_sh - {1'b0, i_opnd};
        if (i_is_div) begin
            // Top bit of the trial difference is the borrow: set means restore.
            if (!w_trial[WIDTH]) begin
                o_acc = {w_trial[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
            end else begin
                o_acc = {w_rem_sh[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            o_acc = {w_sum, i_acc[WIDTH-1:1]};
        end
    end
endmodule
`default_nettype wire

// File: rtl/stage_ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : stage_ex_muldiv
// Brief    : Iterative signed/unsigned multiply/divide unit with tag pass-through.
// Revision : 1.0
// ============================================================================
module stage_ex_muldiv
    import stage_ex_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int TAG_W = DEF_TAG_W,
    parameter int CNT_W = 6
) (
    input wire logic         clk,
    input wire logic         rst_n,
    stage_ex_muldiv_if.slave bus
);
    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               neg_r_q, neg_r_d;
    logic               dz_q, dz_d;
    logic [TAG_W-1:0]   rw_q, rw_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [TAG_W-1:0]   rw_out_q, rw_out_d;
    logic               done_q, done_d;

    logic               w_is_div;
    logic               w_signed;
    logic               w_sign_a;
    logic               w_sign_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [2*WIDTH-1:0] w_acc_step;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo_raw;
    logic [WIDTH-1:0]   w_rem_raw;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    // Magnitudes stay WIDTH bits: the most-negative value maps to 2^(WIDTH-1) unsigned.
    always_comb begin
        w_is_div = (bus.op == MD_DIV) || (bus.op == MD_DIVU);
        w_signed = (bus.op == MD_MUL) || (bus.op == MD_DIV);
        w_sign_a = w_signed & bus.a[WIDTH-1];
        w_sign_b = w_signed & bus.b[WIDTH-1];
        w_mag_a  = w_sign_a ? -bus.a : bus.a;
        w_mag_b  = w_sign_b ? -bus.b : bus.b;
    end

    stage_ex_muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_acc    (acc_q),
        .i_opnd   (opnd_q),
        .i_is_div (is_div_q),
        .o_acc    (w_acc_step)
    );

    always_comb begin
        w_prod    = neg_q ? -acc_q : acc_q;
        w_quo_raw = acc_q[WIDTH-1:0];
        w_rem_raw = acc_q[2*WIDTH-1:WIDTH];
        w_quo     = neg_q ? -w_quo_raw : w_quo_raw;
        w_rem     = neg_r_q ? -w_rem_raw : w_rem_raw;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        a_d      = a_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        neg_r_d  = neg_r_q;
        dz_d     = dz_q;
        rw_d     = rw_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        rw_out_d = rw_out_q;
        done_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.flush) begin
                    state_d  = ST_RUN;
                    cnt_d    = CNT_W'(WIDTH);
                    acc_d    = {{WIDTH{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
                    opnd_d   = w_is_div ? w_mag_b : w_mag_a;
                    a_d      = bus.a;
                    is_div_d = w_is_div;
                    neg_d    = w_sign_a ^ w_sign_b;
                    neg_r_d  = w_sign_a;
                    dz_d     = (bus.b == '0);
                    rw_d     = bus.rw_in;
                end
            end
            ST_RUN: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = w_acc_step;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_FIX;
                    end
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (!bus.flush) begin
                    done_d   = 1'b1;
                    rw_out_d = rw_q;
                    if (!is_div_q) begin
                        hi_d = w_prod[2*WIDTH-1:WIDTH];
                        lo_d = w_prod[WIDTH-1:0];
                    end else if (dz_q) begin
                        hi_d = a_q;
                        lo_d = '1;
                    end else begin
                        hi_d = w_rem;
                        lo_d = w_quo;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            a_q      <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            neg_r_q  <= 1'b0;
            dz_q     <= 1'b0;
            rw_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            rw_out_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            a_q      <= a_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            neg_r_q  <= neg_r_d;
            dz_q     <= dz_d;
            rw_q     <= rw_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            rw_out_q <= rw_out_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy   = (state_q != ST_IDLE);
    assign bus.done   = done_q;
    assign bus.hi     = hi_q;
    assign bus.lo     = lo_q;
    assign bus.rw_out = rw_out_q;
endmodule
`default_nettype wire

// File: tb/tb_stage_ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_stage_ex_muldiv
// Brief    : Vector table, hand sequences and random ops against a reference model.
// Revision : 1.0
// ============================================================================
module tb_stage_ex_muldiv;
    import stage_ex_pkg::*;

    localparam int W = 32;
    localparam int T = 5;
    localparam int LAT = W + 1;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;
    logic [W-1:0] last_hi;
    logic [W-1:0] last_lo;

    stage_ex_muldiv_if #(.WIDTH(W), .TAG_W(T)) bus ();

    stage_ex_muldiv #(.WIDTH(W), .TAG_W(T), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [T-1:0] tag;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV / and % already truncate toward zero.
    function automatic logic [63:0] ref_md(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        longint     p;
        int         q;
        int         r;
        logic [63:0] res;
        res = '0;
        case (op)
            MD_MUL: begin
                p   = longint'($signed(a)) * longint'($signed(b));
                res = p;
            end
            MD_MULU: res = {32'h0, a} * {32'h0, b};
            MD_DIV: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {32'h0, a};
                else begin
                    q   = $signed(a) / $signed(b);
                    r   = $signed(a) % $signed(b);
                    res = {r, q};
                end
            end
            default: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else res = {a % b, a / b};
            end
        endcase
        return res;
    endfunction

    task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [T-1:0] tag, input int inject_at,
                         output logic [W-1:0] g_hi, output logic [W-1:0] g_lo,
                         output logic [T-1:0] g_tag, output int lat, output bit busy_ok);
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.rw_in = tag;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        bus.op    = 2'($urandom_range(0, 3));
        bus.rw_in = T'($urandom);
        lat       = 0;
        busy_ok   = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            bus.start = (k == inject_at);
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = k;
                if (bus.busy) busy_ok = 1'b0;
                break;
            end
            if (!bus.busy) busy_ok = 1'b0;
        end
        bus.start = 1'b0;
        g_hi  = bus.hi;
        g_lo  = bus.lo;
        g_tag = bus.rw_out;
    endtask

    task automatic run_check(input string name, input logic [1:0] op, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [T-1:0] tag, input int inject_at,
                             input logic [W-1:0] e_hi, input logic [W-1:0] e_lo);
        logic [W-1:0] g_hi;
        logic [W-1:0] g_lo;
        logic [T-1:0] g_tag;
        int           lat;
        bit           busy_ok;
        do_op(op, a, b, tag, inject_at, g_hi, g_lo, g_tag, lat, busy_ok);
        chk({name, ".latency"}, 64'(lat), 64'(LAT));
        chk({name, ".busy"}, 64'(busy_ok), 64'd1);
        chk({name, ".hi"}, 64'(g_hi), 64'(e_hi));
        chk({name, ".lo"}, 64'(g_lo), 64'(e_lo));
        chk({name, ".tag"}, 64'(g_tag), 64'(tag));
        last_hi = e_hi;
        last_lo = e_lo;
    endtask

    initial begin
        logic [63:0]  m;
        logic [1:0]   rop;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        bit           seen;

        n_chk  = 0;
        n_fail = 0;
        vecs[0]  = '{MD_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h11, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1]  = '{MD_MUL,  32'hFFFF_FFFD, 32'h0000_0007, 5'h02, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[2]  = '{MD_MUL,  32'h8000_0000, 32'h8000_0000, 5'h03, 32'h4000_0000, 32'h0000_0000};
        vecs[3]  = '{MD_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 5'h04, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[4]  = '{MD_DIVU, 32'h0000_0007, 32'h0000_0002, 5'h05, 32'h0000_0001, 32'h0000_0003};
        vecs[5]  = '{MD_DIVU, 32'h0000_1234, 32'h0000_0000, 5'h06, 32'h0000_1234, 32'hFFFF_FFFF};
        vecs[6]  = '{MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'h07, 32'h0000_0000, 32'h8000_0000};
        vecs[7]  = '{MD_DIV,  32'h0000_0007, 32'hFFFF_FFFE, 5'h08, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[8]  = '{MD_DIV,  32'hFFFF_FFFB, 32'h0000_0000, 5'h09, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
        vecs[9]  = '{MD_MULU, 32'h0000_0000, 32'h1234_5678, 5'h0A, 32'h0000_0000, 32'h0000_0000};
        vecs[10] = '{MD_DIV,  32'h8000_0000, 32'h0000_0001, 5'h1F, 32'h0000_0000, 32'h8000_0000};
        vecs[11] = '{MD_DIVU, 32'hFFFF_FFFF, 32'h0000_0001, 5'h0C, 32'h0000_0000, 32'hFFFF_FFFF};

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        bus.rw_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.busy", 64'(bus.busy), 64'd0);
        chk("reset.done", 64'(bus.done), 64'd0);
        chk("reset.hi", 64'(bus.hi), 64'd0);
        chk("reset.lo", 64'(bus.lo), 64'd0);
        chk("reset.tag", 64'(bus.rw_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Consecutive calls issue each start in the previous done cycle.
        for (int i = 0; i < 12; i++) begin
            run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, 0,
                      vecs[i].hi, vecs[i].lo);
        end

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 9))
                0:       rb = '0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = W'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            m = ref_md(rop, ra, rb);
            run_check($sformatf("rand%0d", i), rop, ra, rb, T'($urandom), 0, m[63:32], m[31:0]);
        end

        // Flush at iteration 10 of a divide.
        bus.op = MD_DIV; bus.a = 32'd100; bus.b = 32'd7; bus.rw_in = 5'h13; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        chk("flush_run.busy", 64'(bus.busy), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done) seen = 1'b1;
        end
        chk("flush_run.no_done", 64'(seen), 64'd0);
        chk("flush_run.hi", 64'(bus.hi), 64'(last_hi));
        chk("flush_run.lo", 64'(bus.lo), 64'(last_lo));
        run_check("after_flush", MD_MULU, 32'd3, 32'd5, 5'h0D, 0, 32'd0, 32'd15);

        // Flush together with start in IDLE drops the start.
        @(posedge clk);
        #1;
        bus.op = MD_MULU; bus.a = 32'd9; bus.b = 32'd9; bus.start = 1'b1; bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        chk("flush_start.busy", 64'(bus.busy), 64'd0);
        seen = 1'b0;
        repeat (36) begin
            @(posedge clk);
            #1;
            if (bus.done) seen = 1'b1;
        end
        chk("flush_start.no_done", 64'(seen), 64'd0);

        // Flush landing on the FIX edge.
        bus.op = MD_MULU; bus.a = 32'd9; bus.b = 32'd9; bus.rw_in = 5'h0E; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (W) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        chk("flush_fix.done", 64'(bus.done), 64'd0);
        chk("flush_fix.busy", 64'(bus.busy), 64'd0);
        chk("flush_fix.lo", 64'(bus.lo), 64'(last_lo));
        chk("flush_fix.tag", 64'(bus.rw_out), 64'h0D);

        // Start pulsed mid-run is ignored.
        run_check("midstart", MD_MULU, 32'h0001_2345, 32'h0001_0000, 5'h1A, 5, 32'h1, 32'h2345_0000);
        @(posedge clk);
        #1;
        chk("done_pulse_width", 64'(bus.done), 64'd0);

        // Asynchronous reset mid-run, checked before the next edge.
        bus.op = MD_DIVU; bus.a = 32'd50; bus.b = 32'd4; bus.rw_in = 5'h15; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst.busy", 64'(bus.busy), 64'd0);
        chk("async_rst.hi", 64'(bus.hi), 64'd0);
        chk("async_rst.lo", 64'(bus.lo), 64'd0);
        chk("async_rst.tag", 64'(bus.rw_out), 64'd0);
        chk("async_rst.done", 64'(bus.done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_check("post_reset", MD_DIVU, 32'd1000, 32'd3, 5'h16, 0, 32'd1, 32'd333);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
